pipeline_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the RV32I pipelined core.
- Generates the PC load, per-stage load and per-stage flush enables, and the bubble-insertion enables for an N-stage in-order pipeline.
- Handles I/D cache wait stalls, load-use bubbles, and branch/jump redirects.
- Unlike a plain combinational stall/flush scheme, a redirect that arrives while an I-fetch is outstanding is recorded. The back end keeps draining, and the target is applied once the fetch returns, so no in-flight I-cache transaction is abandoned.

---
 rtl/pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush/bubble control for an N-stage in-order RV32I pipeline.
//   Register 0 is the PC; register i (1..NUM_STAGES-1) feeds stage i.
//   A redirect that arrives while an I-fetch is outstanding is parked in
//   pend_target. The front end is then kept full of bubbles, the back end
//   keeps draining, and the PC is loaded from pend_target when the fetch
//   returns. This way no in-flight I-cache transaction is abandoned.
//
// Optional build macro: PIPELINE_HAZARD_CTRL_PERF_EN
//   defined   -> saturating perf counters are implemented
//   undefined -> perf_* outputs are tied to zero (no counter flops)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   imem_req/resp     I-cache request / response
//   dmem_req/resp     D-cache request / response (MEM stage)
//   redirect          taken branch/jump resolved in REDIRECT_STAGE
//   redirect_target   target address of the redirect
//   load_use          load-use hazard flag
//   pc_load, pc_sel   PC load enable; source 0=PC+4, 1=redirect_target, 2=pend_target
//   pend_target       parked redirect target
//   stage_load        load enables of registers 1..NUM_STAGES-1 (bit i-1 = register i)
//   stage_flush       synchronous clears of registers 1..NUM_STAGES-1 (flush beats load)
//   redir_pend        a parked redirect is waiting for the I-fetch to return
//   perf_*            stall-cycle / redirect / bubble counters
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES     = 5,
  parameter int EX_STAGE       = 2,
  parameter int REDIRECT_STAGE = 3,
  parameter int XLEN           = 32,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_target,
  input  logic                  load_use,
  output logic                  pc_load,
  output logic [1:0]            pc_sel,
  output logic [XLEN-1:0]       pend_target,
  output logic [NUM_STAGES-2:0] stage_load,
  output logic [NUM_STAGES-2:0] stage_flush,
  output logic                  redir_pend,
  output logic [CNT_WIDTH-1:0]  perf_stall_cyc,
  output logic [CNT_WIDTH-1:0]  perf_redirects,
  output logic [CNT_WIDTH-1:0]  perf_bubbles
);

  localparam int NR = NUM_STAGES - 1;

  // Registers 1..REDIRECT_STAGE form the front; everything above is the back.
  localparam logic [NR-1:0] FRONT_MASK    = {NR{1'b1}} >> (NR - REDIRECT_STAGE);
  localparam logic [NR-1:0] BACK_MASK     = ~FRONT_MASK;
  // The bubble goes into register EX_STAGE; registers above it keep moving.
  localparam logic [NR-1:0] EX_MASK       = {{(NR-1){1'b0}}, 1'b1} << (EX_STAGE - 1);
  localparam logic [NR-1:0] ABOVE_EX_MASK = {NR{1'b1}} << EX_STAGE;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_REDIR = 2'd1;
  localparam logic [1:0] PC_PEND  = 2'd2;

  typedef enum logic {RUN, REDIR_PEND} state_t;

  state_t          state_q, state_nxt;
  logic [XLEN-1:0] pend_target_q;
  logic            pend_we;
  logic            istall, dstall;

  assign istall      = imem_req & ~imem_resp;
  assign dstall      = dmem_req & ~dmem_resp;
  assign pend_target = pend_target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pend_target_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (pend_we) pend_target_q <= redirect_target;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    pend_we     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = PC_SEQ;
    stage_load  = '0;
    stage_flush = '0;
    redir_pend  = 1'b0;
    if (reset) begin
      stage_flush = '1;
      state_nxt   = RUN;
    end else begin
      case (state_q)
        RUN: begin
          // A D-side stall freezes everything; a pending redirect simply
          // stays asserted at its source and is taken once the stall clears.
          if (!dstall) begin
            if (redirect) begin
              stage_flush = FRONT_MASK;
              stage_load  = BACK_MASK;
              if (istall) begin
                pend_we   = 1'b1;
                state_nxt = REDIR_PEND;
              end else begin
                pc_load = 1'b1;
                pc_sel  = PC_REDIR;
              end
            end else if (!istall) begin
              if (load_use) begin
                stage_flush = EX_MASK;
                stage_load  = ABOVE_EX_MASK;
              end else begin
                pc_load    = 1'b1;
                stage_load = '1;
              end
            end
          end
        end
        REDIR_PEND: begin
          // The front holds only bubbles; the word returned by the outstanding
          // fetch is discarded by the register-1 flush.
          redir_pend  = 1'b1;
          stage_flush = FRONT_MASK;
          stage_load  = dstall ? '0 : BACK_MASK;
          if (imem_resp) begin
            pc_load   = 1'b1;
            pc_sel    = PC_PEND;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                 ev_stall, ev_redirect, ev_bubble, in_run;
  logic [CNT_WIDTH-1:0] stall_cnt_q, redir_cnt_q, bubble_cnt_q;

  assign in_run      = ~reset & (state_q == RUN);
  assign ev_redirect = in_run & ~dstall & redirect;
  assign ev_bubble   = in_run & ~dstall & ~redirect & ~istall & load_use;
  assign ev_stall    = in_run & ~pc_load & ~ev_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      redir_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ev_stall)    stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (ev_redirect) redir_cnt_q  <= sat_inc(redir_cnt_q);
      if (ev_bubble)   bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign perf_stall_cyc = stall_cnt_q;
  assign perf_redirects = redir_cnt_q;
  assign perf_bubbles   = bubble_cnt_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_redirects = '0;
  assign perf_bubbles   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (default parameters: 5 stages, EX=2, redirect=3).
module tb_pipeline_hazard_ctrl;

  localparam int NS = 5;
  localparam int EX = 2;
  localparam int RS = 3;
  localparam int XL = 32;
  localparam int CW = 32;
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, imem_resp, dmem_req, dmem_resp, redirect, load_use;
  logic [XL-1:0] redirect_target;
  logic          pc_load;
  logic [1:0]    pc_sel;
  logic [XL-1:0] pend_target;
  logic [NS-2:0] stage_load, stage_flush;
  logic          redir_pend;
  logic [CW-1:0] perf_stall_cyc, perf_redirects, perf_bubbles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .redirect(redirect), .redirect_target(redirect_target), .load_use(load_use),
    .pc_load(pc_load), .pc_sel(pc_sel), .pend_target(pend_target),
    .stage_load(stage_load), .stage_flush(stage_flush), .redir_pend(redir_pend),
    .perf_stall_cyc(perf_stall_cyc), .perf_redirects(perf_redirects),
    .perf_bubbles(perf_bubbles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the pipeline is doing this cycle, plus the parked
  // redirect and event tallies.
  localparam int K_RESET = 0, K_HOLD = 1, K_REDIR = 2, K_DEFER = 3,
                 K_BUBBLE = 4, K_ADV = 5, K_PEND = 6;
  int            m_kind;
  bit            m_pend;
  logic [XL-1:0] m_target;
  longint        m_stall, m_redir, m_bub;

  logic          e_pc_load, e_rp;
  logic [1:0]    e_pc_sel;
  logic [NS-2:0] e_load, e_flush;

  typedef struct packed {
    logic ir, irs, dr, drs, rd, lu;
    logic       pl;
    logic [1:0] ps;
    logic [3:0] ld, fl;
  } vec_t;
  vec_t vt[13];

  function automatic longint perf_exp(input longint v);
    return PERF ? v : 64'd0;
  endfunction

  function automatic longint bump(input longint v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic irs, input logic dr, input logic drs,
                       input logic rd, input logic [XL-1:0] tgt, input logic lu,
                       input logic rst);
    imem_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    redirect = rd; redirect_target = tgt; load_use = lu; reset = rst;
  endtask

  task automatic model_eval();
    bit is, ds;
    is = imem_req & ~imem_resp;
    ds = dmem_req & ~dmem_resp;
    e_pc_load = 1'b0; e_pc_sel = 2'd0; e_load = '0; e_flush = '0; e_rp = 1'b0;
    if (reset)          m_kind = K_RESET;
    else if (m_pend)    m_kind = K_PEND;
    else if (ds)        m_kind = K_HOLD;
    else if (redirect)  m_kind = is ? K_DEFER : K_REDIR;
    else if (is)        m_kind = K_HOLD;
    else if (load_use)  m_kind = K_BUBBLE;
    else                m_kind = K_ADV;
    for (int i = 1; i < NS; i++) begin
      case (m_kind)
        K_RESET: e_flush[i-1] = 1'b1;
        K_REDIR, K_DEFER: begin
          if (i <= RS) e_flush[i-1] = 1'b1;
          else         e_load[i-1]  = 1'b1;
        end
        K_PEND: begin
          if (i <= RS) e_flush[i-1] = 1'b1;
          else         e_load[i-1]  = !ds;
        end
        K_BUBBLE: begin
          if (i == EX)     e_flush[i-1] = 1'b1;
          else if (i > EX) e_load[i-1]  = 1'b1;
        end
        K_ADV: e_load[i-1] = 1'b1;
        default: ;
      endcase
    end
    case (m_kind)
      K_REDIR: begin e_pc_load = 1'b1; e_pc_sel = 2'd1; end
      K_ADV:   e_pc_load = 1'b1;
      K_PEND: begin
        e_rp = 1'b1;
        if (imem_resp) begin e_pc_load = 1'b1; e_pc_sel = 2'd2; end
      end
      default: ;
    endcase
  endtask

  task automatic model_update();
    case (m_kind)
      K_RESET: begin m_pend = 0; m_target = '0; m_stall = 0; m_redir = 0; m_bub = 0; end
      K_HOLD:  m_stall = bump(m_stall);
      K_REDIR: m_redir = bump(m_redir);
      K_DEFER: begin
        m_redir = bump(m_redir); m_stall = bump(m_stall);
        m_pend = 1; m_target = redirect_target;
      end
      K_BUBBLE: m_bub = bump(m_bub);
      K_PEND:   if (imem_resp) m_pend = 0;
      default: ;
    endcase
  endtask

  task automatic check_model();
    #1;
    model_eval();
    chk("ctl", 64'({pc_load, pc_sel, stage_load, stage_flush, redir_pend}),
               64'({e_pc_load, e_pc_sel, e_load, e_flush, e_rp}));
    chk("pend_target", 64'(pend_target), 64'(m_target));
    chk("perf_stall_cyc", 64'(perf_stall_cyc), perf_exp(m_stall));
    chk("perf_redirects", 64'(perf_redirects), perf_exp(m_redir));
    chk("perf_bubbles", 64'(perf_bubbles), perf_exp(m_bub));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_cycle();
    drive(1, 1, 0, 0, 0, '0, 0, 1);
    check_model();
    tick();
  endtask

  initial begin
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,2'd0,4'b1111,4'b0000};
    vt[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'd0,4'b1111,4'b0000};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,4'b0000,4'b0000};
    vt[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,4'b0000,4'b0000};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,2'd1,4'b1000,4'b0111};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,2'd0,4'b1000,4'b0111};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0,4'b1100,4'b0010};
    vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,2'd1,4'b1000,4'b0111};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,2'd0,4'b0000,4'b0000};
    vt[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,4'b0000,4'b0000};
    vt[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0,4'b0000,4'b0000};
    vt[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,4'b1100,4'b0010};
    vt[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,2'd0,4'b0000,4'b0000};

    m_pend = 0; m_target = '0; m_stall = 0; m_redir = 0; m_bub = 0;

    // Reset held two cycles; the first only checks the forced control outputs
    // because the registers are still undefined before the first edge.
    drive(1, 1, 0, 0, 0, '0, 0, 1);
    #1;
    model_eval();
    chk("rst_flush", 64'(stage_flush), 64'h0f);
    chk("rst_pc_load", 64'(pc_load), 64'h0);
    tick();
    reset_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 0, 0, '0, 0, 0);
      check_model();
      chk("adv_pc_load", 64'(pc_load), 64'h1);
      chk("adv_load", 64'(stage_load), 64'h0f);
      tick();
    end

    // Immediate redirect.
    reset_cycle();
    drive(1, 1, 0, 0, 1, 32'h0000_0100, 0, 0);
    check_model();
    chk("redir_sel", 64'(pc_sel), 64'h1);
    chk("redir_flush", 64'(stage_flush), 64'h07);
    chk("redir_back_load", 64'(stage_load[3]), 64'h1);
    tick();
    chk("redir_count", 64'(perf_redirects), perf_exp(1));

    // Redirect during an outstanding fetch, parked for three cycles.
    reset_cycle();
    drive(1, 0, 0, 0, 1, 32'h0000_0200, 0, 0);
    check_model();
    tick();
    for (int c = 0; c < 3; c++) begin
      // Redirect/load_use during the wait must be ignored; one D-stall cycle
      // holds the back end.
      drive(1, 0, (c == 1), 0, (c == 2), 32'hdead_0000, (c == 0), 0);
      check_model();
      chk("pend_flag", 64'(redir_pend), 64'h1);
      chk("pend_tgt", 64'(pend_target), 64'h200);
      chk("pend_back_load", 64'(stage_load), (c == 1) ? 64'h0 : 64'h8);
      tick();
    end
    drive(1, 1, 0, 0, 0, '0, 0, 0);
    check_model();
    chk("pend_resume", 64'({pc_load, pc_sel}), 64'h6);
    tick();
    drive(1, 1, 0, 0, 0, '0, 0, 0);
    check_model();
    chk("pend_back_run", 64'(redir_pend), 64'h0);
    tick();

    // Single load-use bubble followed by normal advance.
    reset_cycle();
    drive(1, 1, 0, 0, 0, '0, 1, 0);
    check_model();
    chk("lu_pc_load", 64'(pc_load), 64'h0);
    chk("lu_hold_r1", 64'(stage_load[0]), 64'h0);
    chk("lu_flush", 64'(stage_flush), 64'h02);
    tick();
    chk("lu_count", 64'(perf_bubbles), perf_exp(1));
    drive(1, 1, 0, 0, 0, '0, 0, 0);
    check_model();
    chk("lu_after", 64'({pc_load, stage_load}), 64'h1f);
    tick();

    // D-stall with a redirect waiting at its source.
    reset_cycle();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 0, 1, 32'h0000_0300, 0, 0);
      check_model();
      chk("dstall_load", 64'({pc_load, stage_load}), 64'h0);
      tick();
    end
    drive(1, 1, 1, 1, 1, 32'h0000_0300, 0, 0);
    check_model();
    chk("dstall_redir", 64'({pc_load, pc_sel}), 64'h5);
    tick();
    chk("dstall_count", 64'(perf_stall_cyc), perf_exp(4));

    // Reset while a redirect is parked.
    reset_cycle();
    drive(1, 0, 0, 0, 1, 32'h0000_0400, 0, 0);
    check_model();
    tick();
    drive(1, 0, 0, 0, 0, '0, 0, 1);
    check_model();
    chk("pend_rst_flush", 64'({pc_load, stage_load, stage_flush, redir_pend}), 64'h1e);
    tick();
    drive(1, 0, 0, 0, 0, '0, 0, 0);
    check_model();
    chk("pend_rst_flag", 64'(redir_pend), 64'h0);
    chk("pend_rst_tgt", 64'(pend_target), 64'h0);
    tick();

    // Single-cycle vector table, each from a freshly reset RUN state.
    for (int v = 0; v < 13; v++) begin
      reset_cycle();
      drive(vt[v].ir, vt[v].irs, vt[v].dr, vt[v].drs, vt[v].rd,
            32'h0000_1000 + 32'(v), vt[v].lu, 0);
      check_model();
      chk($sformatf("vec%0d", v),
          64'({pc_load, pc_sel, stage_load, stage_flush}),
          64'({vt[v].pl, vt[v].ps, vt[v].ld, vt[v].fl}));
      tick();
    end

    // Randomized traffic against the reference model.
    reset_cycle();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 4) == 0), $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0));
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
